regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised multi-port general-purpose register file for the pipelined CPU: NUM_RD combinational read ports, NUM_WR write-back ports, write-to-read bypass.
- Adds a per-register pending-write scoreboard: ID/issue marks a destination pending, WB retires it, and read ports report whether the value is still outstanding.
- Sits between decode (reads, issue) and the write-back stage(s); the hazard unit consumes rd_busy and iss_stall.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- NUM_WR, 1, number of write-back ports (1..2)
- CNT_W, 2, pending counter width; max outstanding writes per register = 2**CNT_W-1

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- rd_en  in  NUM_RD  per-port read enable
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  read value still awaiting an un-retired write
- wr_en  in  NUM_WR  write-back enables
- wr_addr  in  NUM_WR*ADDR_W  write-back addresses
- wr_data  in  NUM_WR*DATA_W  write-back data
- iss_en  in  1  issue: mark iss_addr pending
- iss_addr  in  ADDR_W  destination of issuing instruction
- iss_stall  out  1  issue refused, counter saturated
- flush  in  1  clear all pending counters (pipeline flush)

Behaviour:
- Reset (rstn low, asynchronous): all registers 0, all pending counters 0. Outputs are combinational from state, so during reset rd_data=0, rd_busy=0, iss_stall=0.
- Register 0: reads 0, never written, never pending; iss_addr=0 and wr_addr=0 are ignored for state.
- Write (posedge): for each enabled port with nonzero address, reg[wr_addr] <= wr_data. If both ports target the same address, port NUM_WR-1 (highest index) wins.
- Read (combinational, zero latency):
  - rd_en=0 -> rd_data=0, rd_busy=0.
  - Otherwise, if any enabled write port matches a nonzero rd_addr, rd_data is that port's wr_data (highest index wins); else rd_data=reg[rd_addr].
- Pending counter cnt[r], updated at posedge as cnt + inc - dec:
  - inc = 1 if iss_en, iss_addr==r, r!=0 and not iss_stall.
  - dec = number of enabled write ports with wr_addr==r (0..NUM_WR).
  - Saturate at 0: dec larger than cnt+inc clamps to 0. Writes with no prior issue still update the data.
- flush: all cnt <= 0 at the same edge; overrides inc and dec. Data writes in that cycle still occur.
- rd_busy[k] = rd_en[k] && rd_addr!=0 && (cnt[rd_addr] - dec[rd_addr]) > 0, computed without underflow. A bypassed final write therefore shows not busy in the same cycle.
- iss_stall = iss_en && iss_addr!=0 && cnt[iss_addr]==max && dec[iss_addr]==0. When stalled, the issue is dropped; the issuer must hold and retry.
- Issue and retire on the same register in the same cycle: net count unchanged.
- No internal FSM beyond the counters; every state change happens on the clock edge or on async reset.

Decomposition:
- Shared include regfile_defs.vh: default DATA_W, ADDR_W, CNT_W and the REG_ZERO address constant, shared with the hazard unit and decode.
- Natural sub-module: reg_pend_cnt, one saturating up/down counter with flush and async reset, instantiated per register 1..2**ADDR_W-1.

Test Plan:
- Reset mid-run: after writing r5=0x1234, assert rstn=0 asynchronously -> read r5=0 immediately, rd_busy=0, counters 0 after release.
- Bypass: wr_en=1, wr_addr=7, wr_data=0xDEADBEEF with rd_addr0=7 in the same cycle -> rd_data0=0xDEADBEEF combinationally; the following cycle reads 0xDEADBEEF from storage.
- Scoreboard: issue r3 twice (cnt=2) -> rd_busy=1. First write to r3 -> still busy. Second write to r3 -> busy=0 in that same cycle via dec.
- Saturation: CNT_W=2, issue r9 three times, then a fourth issue with no write -> iss_stall=1, cnt stays 3. Fourth issue concurrent with a write to r9 -> no stall, cnt stays 3.
- Dual write (NUM_WR=2): both ports write r4 with 0x11 and 0x22 -> r4=0x22, rd bypass=0x22, cnt[r4] decremented by 2 (clamped at 0).
- Register 0 and flush: write 0xFF to r0 and issue r0 -> reads 0, never busy. Issue r6, then flush with concurrent issue r6 -> cnt[r6]=0, rd_busy=0 next cycle.

Source files
------------

// File: rtl/regfile_scoreboard_pkg.sv
// Shared register-file constants, also used by decode and the hazard unit.
package regfile_scoreboard_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned DEF_CNT_W  = 2;
    localparam int unsigned DEF_NUM_RD = 2;
    localparam int unsigned DEF_NUM_WR = 1;
    localparam int unsigned REG_ZERO   = 0;

    // Bits needed to count 0..numWr simultaneous retirements of one register.
    function automatic int unsigned decWidth(input int unsigned numWr);
        return $clog2(numWr + 1);
    endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/write-back side bundle for the register file and its scoreboard.
interface regfile_scoreboard_if
    import regfile_scoreboard_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned NUM_RD = DEF_NUM_RD,
    parameter int unsigned NUM_WR = DEF_NUM_WR
);

    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     iss_stall;
    logic                     flush;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        input  rd_data, rd_busy, iss_stall
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        output rd_data, rd_busy, iss_stall
    );

endinterface

// File: rtl/reg_pend_cnt.sv
// Pending-write counter for one register: +inc, -dec, clamped at zero, flushable.
module reg_pend_cnt #(
    parameter int unsigned CNT_W = 2,
    parameter int unsigned DEC_W = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             inc,
    input  logic [DEC_W-1:0] dec,
    output logic [CNT_W-1:0] cnt
);

    localparam int unsigned SUM_W = (CNT_W + 1 > DEC_W) ? CNT_W + 1 : DEC_W;

    logic [CNT_W-1:0] cntQ, cntD;
    logic [SUM_W-1:0] sum;

    // Next count; the issuer never increments a full counter unless a retire frees a slot.
    always_comb begin
        sum  = SUM_W'(cntQ) + SUM_W'(inc);
        cntD = cntQ;
        if (flush) begin
            cntD = '0;
        end else if (SUM_W'(dec) >= sum) begin
            cntD = '0;
        end else begin
            cntD = CNT_W'(sum - SUM_W'(dec));
        end
    end

    // Counter state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cntQ <= '0;
        end else begin
            cntQ <= cntD;
        end
    end

    assign cnt = cntQ;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with write-to-read bypass and a per-register
// pending-write scoreboard for the hazard unit.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned NUM_RD = DEF_NUM_RD,
    parameter int unsigned NUM_WR = DEF_NUM_WR,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input logic                 clk,
    input logic                 rstn,
    regfile_scoreboard_if.slave bus
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned DEC_W = decWidth(NUM_WR);
    localparam int unsigned CMP_W = (CNT_W > DEC_W) ? CNT_W : DEC_W;
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0]        regQ   [DEPTH];
    logic [CNT_W-1:0]         cntArr [DEPTH];
    logic [DEC_W-1:0]         decArr [DEPTH];
    logic                     issStall;
    logic [ADDR_W-1:0]        rAddr;
    logic [ADDR_W-1:0]        wAddr;
    logic [NUM_RD*DATA_W-1:0] rdData;
    logic [NUM_RD-1:0]        rdBusy;

    // Retirements landing on each register this cycle (r0 never retires).
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            decArr[r] = '0;
            for (int w = 0; w < NUM_WR; w++) begin
                if (r != 0 && bus.wr_en[w] && bus.wr_addr[w*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
                    decArr[r] = decArr[r] + DEC_W'(1);
                end
            end
        end
    end

    // A full counter refuses the issue unless a retire on the same register frees a slot.
    assign issStall = bus.iss_en && (bus.iss_addr != ZERO_A) &&
                      (cntArr[bus.iss_addr] == CNT_MAX) && (decArr[bus.iss_addr] == '0);
    assign bus.iss_stall = issStall;

    assign cntArr[0] = '0;

    for (genvar r = 1; r < DEPTH; r++) begin : gCnt
        logic incR;
        assign incR = bus.iss_en && (bus.iss_addr == ADDR_W'(r)) && !issStall;

        reg_pend_cnt #(
            .CNT_W (CNT_W),
            .DEC_W (DEC_W)
        ) uCnt (
            .clk   (clk),
            .rstn  (rstn),
            .flush (bus.flush),
            .inc   (incR),
            .dec   (decArr[r]),
            .cnt   (cntArr[r])
        );
    end

    // Storage write-back; iterating upward lets the highest port win an address clash.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < DEPTH; r++) begin
                regQ[r] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (bus.wr_en[w] && bus.wr_addr[w*ADDR_W +: ADDR_W] != ZERO_A) begin
                    regQ[bus.wr_addr[w*ADDR_W +: ADDR_W]] <= bus.wr_data[w*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Read ports: storage or bypassed write data, plus outstanding-write flag net of retires.
    always_comb begin
        rdData = '0;
        rdBusy = '0;
        rAddr  = '0;
        wAddr  = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rAddr = bus.rd_addr[k*ADDR_W +: ADDR_W];
            if (bus.rd_en[k] && rAddr != ZERO_A) begin
                rdData[k*DATA_W +: DATA_W] = regQ[rAddr];
                for (int w = 0; w < NUM_WR; w++) begin
                    wAddr = bus.wr_addr[w*ADDR_W +: ADDR_W];
                    if (bus.wr_en[w] && wAddr == rAddr) begin
                        rdData[k*DATA_W +: DATA_W] = bus.wr_data[w*DATA_W +: DATA_W];
                    end
                end
                rdBusy[k] = CMP_W'(cntArr[rAddr]) > CMP_W'(decArr[rAddr]);
            end
        end
    end

    assign bus.rd_data = rdData;
    assign bus.rd_busy = rdBusy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: 2 read ports, 2 write ports, CNT_W=2.
module tb_regfile_scoreboard;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 2;
    localparam int unsigned NW = 2;

    logic clk;
    logic rstn;
    int   nCmp = 0;
    int   nErr = 0;

    regfile_scoreboard_if #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .NUM_RD (NR),
        .NUM_WR (NW)
    ) bus ();

    regfile_scoreboard #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .NUM_RD (NR),
        .NUM_WR (NW),
        .CNT_W  (2)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.rd_en    = '0;
        bus.rd_addr  = '0;
        bus.wr_en    = '0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.iss_en   = 1'b0;
        bus.iss_addr = '0;
        bus.flush    = 1'b0;
    endtask

    task automatic setRd(input int k, input logic [AW-1:0] a);
        bus.rd_en[k]             = 1'b1;
        bus.rd_addr[k*AW +: AW]  = a;
    endtask

    task automatic setWr(input int w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wr_en[w]             = 1'b1;
        bus.wr_addr[w*AW +: AW]  = a;
        bus.wr_data[w*DW +: DW]  = d;
    endtask

    task automatic setIss(input logic [AW-1:0] a);
        bus.iss_en   = 1'b1;
        bus.iss_addr = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rdData(input int k);
        return bus.rd_data[k*DW +: DW];
    endfunction

    initial begin
        idle();
        rstn = 1'b0;
        setRd(0, 5'd5);
        setIss(5'd9);
        #12;
        check("rst_data",  rdData(0), 32'h0);
        check("rst_busy",  32'(bus.rd_busy), 32'h0);
        check("rst_stall", 32'(bus.iss_stall), 32'h0);
        rstn = 1'b1;
        tick();

        // Write r5, mark it pending, then reset asynchronously mid-cycle.
        idle();
        setWr(0, 5'd5, 32'h1234);
        tick();
        idle();
        setIss(5'd5);
        tick();
        idle();
        setRd(0, 5'd5);
        #1;
        check("pre_rst_data", rdData(0), 32'h1234);
        check("pre_rst_busy", 32'(bus.rd_busy[0]), 32'h1);
        rstn = 1'b0;
        #1;
        check("async_rst_data", rdData(0), 32'h0);
        check("async_rst_busy", 32'(bus.rd_busy[0]), 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        check("post_rst_data", rdData(0), 32'h0);
        check("post_rst_busy", 32'(bus.rd_busy[0]), 32'h0);

        // Bypass of a write to r7; port 1 points at r7 but is disabled.
        idle();
        setWr(0, 5'd7, 32'hDEADBEEF);
        setRd(0, 5'd7);
        bus.rd_addr[AW +: AW] = 5'd7;
        #1;
        check("bypass_r7",   rdData(0), 32'hDEADBEEF);
        check("rd_disabled", rdData(1), 32'h0);
        tick();
        idle();
        setRd(0, 5'd7);
        #1;
        check("stored_r7", rdData(0), 32'hDEADBEEF);

        // Two issues to r3, then two retires.
        idle();
        setIss(5'd3);
        #1;
        check("iss_r3_nostall", 32'(bus.iss_stall), 32'h0);
        tick();
        tick();
        idle();
        setRd(1, 5'd3);
        #1;
        check("r3_busy_cnt2", 32'(bus.rd_busy[1]), 32'h1);
        setWr(0, 5'd3, 32'h33);
        #1;
        check("r3_busy_wr1",   32'(bus.rd_busy[1]), 32'h1);
        check("r3_bypass_wr1", rdData(1), 32'h33);
        tick();
        idle();
        setRd(1, 5'd3);
        setWr(1, 5'd3, 32'h44);
        #1;
        check("r3_free_wr2",   32'(bus.rd_busy[1]), 32'h0);
        check("r3_bypass_wr2", rdData(1), 32'h44);
        tick();
        idle();
        setRd(1, 5'd3);
        #1;
        check("r3_idle_busy", 32'(bus.rd_busy[1]), 32'h0);
        check("r3_idle_data", rdData(1), 32'h44);

        // Saturate r9 at 3 outstanding writes.
        idle();
        setIss(5'd9);
        tick();
        tick();
        tick();
        #1;
        check("r9_stall_full", 32'(bus.iss_stall), 32'h1);
        tick();
        setWr(0, 5'd9, 32'h99);
        #1;
        check("r9_nostall_retire", 32'(bus.iss_stall), 32'h0);
        tick();
        idle();
        setIss(5'd9);
        #1;
        check("r9_still_full", 32'(bus.iss_stall), 32'h1);
        idle();
        setRd(0, 5'd9);
        setWr(0, 5'd9, 32'h9A);
        #1;
        check("r9_busy_c3", 32'(bus.rd_busy[0]), 32'h1);
        tick();
        #1;
        check("r9_busy_c2", 32'(bus.rd_busy[0]), 32'h1);
        tick();
        #1;
        check("r9_free_c1", 32'(bus.rd_busy[0]), 32'h0);
        tick();
        idle();
        setRd(0, 5'd9);
        #1;
        check("r9_drained", 32'(bus.rd_busy[0]), 32'h0);

        // Dual write to r4 with one outstanding issue: clamp at zero.
        idle();
        setIss(5'd4);
        tick();
        idle();
        setRd(0, 5'd4);
        #1;
        check("r4_busy", 32'(bus.rd_busy[0]), 32'h1);
        setWr(0, 5'd4, 32'h11);
        setWr(1, 5'd4, 32'h22);
        #1;
        check("r4_dual_bypass", rdData(0), 32'h22);
        check("r4_dual_busy",   32'(bus.rd_busy[0]), 32'h0);
        tick();
        idle();
        setRd(0, 5'd4);
        #1;
        check("r4_stored", rdData(0), 32'h22);
        check("r4_clamped_busy", 32'(bus.rd_busy[0]), 32'h0);
        setIss(5'd4);
        #1;
        check("r4_clamped_nostall", 32'(bus.iss_stall), 32'h0);
        tick();
        #1;
        check("r4_reissue_busy", 32'(bus.rd_busy[0]), 32'h1);

        // Register 0 ignores writes and issues.
        idle();
        setWr(0, 5'd0, 32'hFF);
        setIss(5'd0);
        setRd(0, 5'd0);
        #1;
        check("r0_bypass", rdData(0), 32'h0);
        check("r0_busy",   32'(bus.rd_busy[0]), 32'h0);
        check("r0_stall",  32'(bus.iss_stall), 32'h0);
        tick();
        tick();
        tick();
        tick();
        idle();
        setRd(0, 5'd0);
        #1;
        check("r0_data_after", rdData(0), 32'h0);
        check("r0_busy_after", 32'(bus.rd_busy[0]), 32'h0);

        // Flush overrides a concurrent issue; the data write still lands.
        idle();
        setIss(5'd6);
        tick();
        idle();
        setRd(1, 5'd6);
        #1;
        check("r6_busy", 32'(bus.rd_busy[1]), 32'h1);
        bus.flush = 1'b1;
        setIss(5'd6);
        setWr(0, 5'd6, 32'h66);
        tick();
        idle();
        setRd(1, 5'd6);
        #1;
        check("r6_flushed_busy", 32'(bus.rd_busy[1]), 32'h0);
        check("r6_flush_write",  rdData(1), 32'h66);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
